regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 8-bit register file: drives write, D_address and data_in.
- After reset, sweeps every register to zero.
- Then shares the write port among NREQ requesters (ALU writeback, load unit, debug port) using round-robin and a valid/ready handshake.
- Sits between the execution units and the register file. Read ports (A/B) are untouched.

Parameters:
- DW, 8, data width of a register.
- AW, 8, register address width.
- DEPTH, 256, number of registers swept by clear; DEPTH <= 2**AW.
- NREQ, 3, number of write requesters; must be >= 2.
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- soft_clear  in  1  pulse: re-run zero sweep.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  NREQ*AW  requester i destination address, slice [i*AW +: AW].
- req_data  in  NREQ*DW  requester i write data, slice [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer happens when req_valid[i] && req_ready[i].
- write  out  1  regfile write enable.
- D_address  out  AW  regfile write address.
- data_in  out  DW  regfile write data.
- init_done  out  1  high once the clear sweep has finished.
- busy  out  1  high during the clear sweep.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values, sampled at the clk edge with rst_n=0:
  - write=0, D_address=0, data_in=0.
  - req_ready=0, init_done=0, busy=0.
  - rr_ptr=0, clr_cnt=0.
  - state=CLEAR if CLEAR_ON_RESET, else RUN.
- A reset asserted mid-sweep or mid-transfer aborts it immediately. No partial write is issued in the reset cycle.
- States:
  - CLEAR:
    - Each cycle, registered outputs are write=1, D_address=clr_cnt, data_in=0; clr_cnt increments.
    - After the cycle with clr_cnt=DEPTH-1: go to RUN, init_done=1, busy=0.
    - busy=1 throughout the sweep; req_ready=0.
  - RUN:
    - req_ready is combinational from req_valid and rr_ptr.
    - Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
    - At most one bit of req_ready is set. req_ready=0 when no valid is set.
    - On a transfer from requester g: next cycle write=1, D_address=req_addr[g], data_in=req_data[g]; rr_ptr=(g+1) mod NREQ.
    - No transfer: next cycle write=0; D_address and data_in hold their previous value; rr_ptr unchanged.
- Latency: handshake at edge k → regfile write at edge k+1. Sustained throughput is one write per cycle.
- soft_clear sampled 1 in RUN:
  - req_ready forced to 0 that cycle, so no transfer happens.
  - Next state is CLEAR with clr_cnt=0 and init_done=0.
  - A write registered from the previous cycle still completes.
- soft_clear during CLEAR is ignored; the sweep is not restarted.
- Fairness: a continuously-valid requester is granted within NREQ transfers.
- Requester rules: req_addr and req_data must be stable while req_valid=1 and not yet granted. The arbiter does not check this.
- Addresses >= DEPTH are passed through unmodified; the regfile decodes them.
- init_done stays high in RUN; it falls only on reset or soft_clear.

Decomposition:
- Shared package regfile_pkg:
  - constants RF_DW=8, RF_AW=8, RF_DEPTH=256.
  - state encoding ST_CLEAR, ST_RUN.
- One natural sub-module: rr_arbiter, parameter N.
  - Inputs: req[N], ptr.
  - Output: one-hot gnt[N] plus encoded index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset sweep, with DEPTH=4 and CLEAR_ON_RESET=1:
  - Stimulus: rst_n low 3 cycles, then high.
  - Response: write=1 with D_address 0,1,2,3 and data_in=0 on 4 consecutive cycles; busy=1 during them; then init_done=1, busy=0, write=0.
- Single request:
  - Stimulus: in RUN, req_valid=3'b010, req_addr[1]=8'h01, req_data[1]=8'hAA for one cycle.
  - Response: req_ready=3'b010 that cycle; next cycle write=1, D_address=8'h01, data_in=8'hAA; following cycle write=0.
- Round-robin:
  - Stimulus: req_valid=3'b111 held with rr_ptr=0; data 8'h10, 8'h11, 8'h12.
  - Response: grants in order 001, 010, 100, 001; writes of 8'h10, 8'h11, 8'h12, 8'h10 on consecutive cycles.
- soft_clear collision:
  - Stimulus: soft_clear=1 and req_valid=3'b001 in the same cycle.
  - Response: req_ready=0; next cycle write=1, D_address=0, data_in=0; init_done=0 until the sweep ends; then req 0 is granted.
- Reset mid-sweep:
  - Stimulus: rst_n=0 while clr_cnt=2.
  - Response: next cycle write=0, busy=0, init_done=0; after release, the sweep restarts at D_address=0.
- CLEAR_ON_RESET=0:
  - Stimulus: release reset with req_valid=3'b100, req_addr[2]=8'h03, req_data[2]=8'h03.
  - Response: granted in the first cycle after release; init_done=1 from that cycle; one write to 8'h03 of 8'h03.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the register-file write port
package regfile_pkg;

    localparam int RF_DW    = 8;
    localparam int RF_AW    = 8;
    localparam int RF_DEPTH = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting at ptr
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((32'(ptr) + 32'(k)) % 32'(N));
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write port owner: zero sweep, then round-robin sharing
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DW             = RF_DW,
    parameter int AW             = RF_AW,
    parameter int DEPTH          = RF_DEPTH,
    parameter int NREQ           = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_clear,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               write,
    output logic [AW-1:0]      D_address,
    output logic [DW-1:0]      data_in,
    output logic               init_done,
    output logic               busy
);

    localparam int            PW       = $clog2(NREQ);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    rf_state_e     r_state, w_state_nxt;
    logic          r_write, w_write_nxt;
    logic [AW-1:0] r_addr,  w_addr_nxt;
    logic [DW-1:0] r_data,  w_data_nxt;
    logic          r_busy,  w_busy_nxt;
    logic [PW-1:0] r_ptr,   w_ptr_nxt;
    logic [AW-1:0] r_clr_cnt, w_clr_nxt;

    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_idx;
    logic            w_run_ok;

    rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // Grants are suppressed in reset and on a soft_clear cycle so no transfer can be lost.
    assign w_run_ok  = rst_n && (r_state == ST_RUN) && !soft_clear;
    assign req_ready = w_run_ok ? w_gnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_clr_nxt   = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = r_clr_cnt;
                w_data_nxt  = '0;
                w_busy_nxt  = 1'b1;
                w_clr_nxt   = r_clr_cnt + AW'(1);
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_clr_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (soft_clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_nxt   = '0;
                end else if (|w_gnt) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = req_addr[w_idx*AW +: AW];
                    w_data_nxt  = req_data[w_idx*DW +: DW];
                    w_ptr_nxt   = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_write   <= w_write_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_busy    <= w_busy_nxt;
            r_ptr     <= w_ptr_nxt;
            r_clr_cnt <= w_clr_nxt;
        end
    end

    assign write     = r_write;
    assign D_address = r_addr;
    assign data_in   = r_data;
    assign busy      = r_busy;
    // Done only once the last sweep write has left the output registers.
    assign init_done = rst_n && (r_state == ST_RUN) && !r_busy;

endmodule
